ram_port_arbiter: RTL and testbench



---
 rtl/ram_port_arbiter_pkg.sv | 14 +
 rtl/ram_port_arbiter_rr_pick.sv | 34 +++
 rtl/ram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port arbiter and its picker.
package ram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Increment an index and wrap it back to zero at n.
  function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Rotating-priority picker: grants the first set request at or after ptr_i, wrapping.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  int unsigned j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 32'(ptr_i);
    for (int k = 0; k < N; k++) begin
      if (!any_o && req_i[j[W-1:0]]) begin
        idx_o = W'(j);
        any_o = 1'b1;
      end
      j = mod_inc(j, N);
    end
    if (any_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among N_REQ requesters, with burst
// hold and a two-stage read pipeline returning data to the issuing requester.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 32,
  parameter int DEPTH_L2 = $clog2(DEPTH),
  parameter int N_REQ_L2 = $clog2(N_REQ),
  parameter int BURST    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*DEPTH_L2-1:0] req_addr,
  input  logic [N_REQ*WIDTH-1:0]    req_wdata,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      ram_wr_valid,
  output logic [DEPTH_L2-1:0]       ram_wr_addr,
  output logic [WIDTH-1:0]          ram_wr_data,
  output logic                      ram_rd_valid,
  output logic [DEPTH_L2-1:0]       ram_rd_addr,
  input  logic                      ram_rd_ready,
  input  logic [WIDTH-1:0]          ram_rd_data
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  arb_state_t          state_q, state_d;
  logic [N_REQ_L2-1:0] own_q, own_d;
  logic [N_REQ_L2-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [N_REQ_L2-1:0] ptr_rel;
  logic [N_REQ_L2-1:0] pick_ptr;
  logic [N_REQ-1:0]    pick_gnt;
  logic [N_REQ_L2-1:0] pick_idx;
  logic                pick_any;
  logic                keep;

  logic [N_REQ_L2-1:0] acc_idx;
  logic                acc;
  logic                acc_we;
  logic [DEPTH_L2-1:0] acc_addr;
  logic [WIDTH-1:0]    acc_wdata;

  logic [DEPTH_L2-1:0] addr_arr  [N_REQ];
  logic [WIDTH-1:0]    wdata_arr [N_REQ];

  logic                wr_valid_q;
  logic [DEPTH_L2-1:0] wr_addr_q;
  logic [WIDTH-1:0]    wr_data_q;
  logic                rd_valid_q;
  logic [DEPTH_L2-1:0] rd_addr_q;
  logic [N_REQ_L2-1:0] rd_tag_q;
  logic                rd_pend_q;
  logic [N_REQ_L2-1:0] rsp_tag_q;

  // The read-complete flag from the RAM is not needed: the response comes
  // from the internal pipeline alone.
  logic unused_rd_ready;
  assign unused_rd_ready = ram_rd_ready;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*DEPTH_L2 +: DEPTH_L2];
    assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
  end

  assign ptr_rel  = N_REQ_L2'(mod_inc(32'(own_q), N_REQ));
  assign keep     = (state_q == HOLD) && req_valid[own_q] && (cnt_q != CNT_LAST);
  // On release the scan restarts just past the old owner in the same cycle.
  assign pick_ptr = (state_q == HOLD) ? ptr_rel : ptr_q;

  rr_pick #(
    .N (N_REQ),
    .W (N_REQ_L2)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (pick_ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    acc_idx   = own_q;
    if (!rst) begin
      if (keep) begin
        req_ready[own_q] = 1'b1;
        cnt_d            = cnt_q + 1'b1;
      end else begin
        if (state_q == HOLD) begin
          ptr_d = ptr_rel;
        end
        req_ready = pick_gnt;
        acc_idx   = pick_idx;
        if (pick_any) begin
          state_d = HOLD;
          own_d   = pick_idx;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  assign acc       = |req_ready;
  assign acc_we    = req_we[acc_idx];
  assign acc_addr  = addr_arr[acc_idx];
  assign acc_wdata = wdata_arr[acc_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      own_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_tag_q   <= '0;
      rd_pend_q  <= 1'b0;
      rsp_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      wr_valid_q <= acc && acc_we;
      rd_valid_q <= acc && !acc_we;
      if (acc && acc_we) begin
        wr_addr_q <= acc_addr;
        wr_data_q <= acc_wdata;
      end
      if (acc && !acc_we) begin
        rd_addr_q <= acc_addr;
        rd_tag_q  <= acc_idx;
      end
      // Tag follows the strobe one stage so back-to-back reads keep their issuer.
      rd_pend_q <= rd_valid_q;
      rsp_tag_q <= rd_tag_q;
    end
  end

  always_comb begin
    rsp_valid            = '0;
    rsp_valid[rsp_tag_q] = rd_pend_q;
  end

  assign rsp_data     = ram_rd_data;
  assign ram_wr_valid = wr_valid_q;
  assign ram_wr_addr  = wr_addr_q;
  assign ram_wr_data  = wr_data_q;
  assign ram_rd_valid = rd_valid_q;
  assign ram_rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench: two arbiters (BURST=4 and BURST=1) share stimulus; each is checked
// against a rule-level arbitration model and an in-order memory scoreboard.
module tb_ram_port_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int NI    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_we;
  logic [N*AW-1:0]    req_addr;
  logic [N*WIDTH-1:0] req_wdata;

  logic [N-1:0]     req_ready_w [NI];
  logic [N-1:0]     rsp_valid_w [NI];
  logic [WIDTH-1:0] rsp_data_w  [NI];
  logic             wr_v_w      [NI];
  logic [AW-1:0]    wr_a_w      [NI];
  logic [WIDTH-1:0] wr_d_w      [NI];
  logic             rd_v_w      [NI];
  logic [AW-1:0]    rd_a_w      [NI];
  logic             rd_rdy_w    [NI];
  logic [WIDTH-1:0] rd_dat_w    [NI];
  logic             pend_w      [NI];

  ram_port_arbiter #(.N_REQ(N), .DEPTH(DEPTH), .WIDTH(WIDTH), .BURST(4)) dut_b4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_w[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]),
    .ram_wr_valid(wr_v_w[0]), .ram_wr_addr(wr_a_w[0]), .ram_wr_data(wr_d_w[0]),
    .ram_rd_valid(rd_v_w[0]), .ram_rd_addr(rd_a_w[0]),
    .ram_rd_ready(rd_rdy_w[0]), .ram_rd_data(rd_dat_w[0])
  );

  ram_port_arbiter #(.N_REQ(N), .DEPTH(DEPTH), .WIDTH(WIDTH), .BURST(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_w[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]),
    .ram_wr_valid(wr_v_w[1]), .ram_wr_addr(wr_a_w[1]), .ram_wr_data(wr_d_w[1]),
    .ram_rd_valid(rd_v_w[1]), .ram_rd_addr(rd_a_w[1]),
    .ram_rd_ready(rd_rdy_w[1]), .ram_rd_data(rd_dat_w[1])
  );

  assign pend_w[0] = dut_b4.rd_pend_q;
  assign pend_w[1] = dut_b1.rd_pend_q;

  // Registered single-port RAM behind each arbiter.
  logic             ram_clear;
  logic [WIDTH-1:0] ram_mem [NI][DEPTH];

  always @(posedge clk) begin
    for (int n = 0; n < NI; n++) begin
      if (ram_clear) begin
        for (int a = 0; a < DEPTH; a++) ram_mem[n][a] <= '0;
      end else if (wr_v_w[n]) begin
        ram_mem[n][wr_a_w[n]] <= wr_d_w[n];
      end
      if (rd_v_w[n]) rd_dat_w[n] <= ram_mem[n][rd_a_w[n]];
      rd_rdy_w[n] <= rst ? 1'b0 : rd_v_w[n];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: arbitration rules and an in-order memory image.
  int               m_own  [NI];
  int               m_cnt  [NI];
  int               m_ptr  [NI];
  bit               m_hold [NI];
  logic [WIDTH-1:0] mem_ref [NI][DEPTH];

  bit               e_wr_v [NI];
  logic [AW-1:0]    e_wr_a [NI];
  logic [WIDTH-1:0] e_wr_d [NI];
  bit               e_rd_v [NI];
  logic [AW-1:0]    e_rd_a [NI];
  bit               e_r1_v [NI], e_r2_v [NI];
  int               e_r1_t [NI], e_r2_t [NI];
  logic [WIDTH-1:0] e_r1_d [NI], e_r2_d [NI];

  logic [AW-1:0]    drv_addr [N];
  logic [WIDTH-1:0] drv_data [N];
  int               addr_max;

  function automatic int burst_of(input int n);
    return (n == 0) ? 4 : 1;
  endfunction

  function automatic void model_reset(input int n);
    m_own[n] = 0; m_cnt[n] = 0; m_ptr[n] = 0; m_hold[n] = 1'b0;
  endfunction

  function automatic int model_grant(input int n, input logic [N-1:0] v);
    int j;
    if (m_hold[n] && v[m_own[n]] && m_cnt[n] < burst_of(n) - 1) begin
      m_cnt[n]++;
      return m_own[n];
    end
    if (m_hold[n]) m_ptr[n] = (m_own[n] + 1) % N;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr[n] + k) % N;
      if (v[j]) begin
        m_hold[n] = 1'b1; m_own[n] = j; m_cnt[n] = 0;
        return j;
      end
    end
    m_hold[n] = 1'b0;
    return -1;
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      drv_addr[i] = AW'($urandom_range(0, addr_max));
      drv_data[i] = $urandom;
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] we, input bit r);
    int            g;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_rsp;
    string         p;
    rst       = r;
    req_valid = v;
    req_we    = we;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]       = drv_addr[i];
      req_wdata[i*WIDTH +: WIDTH] = drv_data[i];
    end
    @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      p = $sformatf("B%0d", burst_of(n));
      if (r) begin
        model_reset(n);
        g = -1;
      end else begin
        g = model_grant(n, v);
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk({p, ".req_ready"}, 64'(req_ready_w[n]), 64'(exp_rdy));
      chk({p, ".wr_valid"}, 64'(wr_v_w[n]), 64'(e_wr_v[n]));
      chk({p, ".wr_addr"}, 64'(wr_a_w[n]), 64'(e_wr_a[n]));
      chk({p, ".wr_data"}, 64'(wr_d_w[n]), 64'(e_wr_d[n]));
      chk({p, ".rd_valid"}, 64'(rd_v_w[n]), 64'(e_rd_v[n]));
      chk({p, ".rd_addr"}, 64'(rd_a_w[n]), 64'(e_rd_a[n]));
      exp_rsp = '0;
      if (e_r2_v[n]) exp_rsp[e_r2_t[n]] = 1'b1;
      chk({p, ".rsp_valid"}, 64'(rsp_valid_w[n]), 64'(exp_rsp));
      if (e_r2_v[n]) chk({p, ".rsp_data"}, 64'(rsp_data_w[n]), 64'(e_r2_d[n]));
      chk({p, ".rd_ready_vs_pend"}, 64'(rd_rdy_w[n]), 64'(pend_w[n]));

      if (r) begin
        e_r1_v[n] = 1'b0; e_r2_v[n] = 1'b0;
        e_wr_v[n] = 1'b0; e_rd_v[n] = 1'b0;
        e_wr_a[n] = '0;   e_wr_d[n] = '0;  e_rd_a[n] = '0;
      end else begin
        e_r2_v[n] = e_r1_v[n]; e_r2_t[n] = e_r1_t[n]; e_r2_d[n] = e_r1_d[n];
        e_r1_v[n] = 1'b0; e_wr_v[n] = 1'b0; e_rd_v[n] = 1'b0;
        if (g >= 0) begin
          if (we[g]) begin
            e_wr_v[n] = 1'b1; e_wr_a[n] = drv_addr[g]; e_wr_d[n] = drv_data[g];
            mem_ref[n][drv_addr[g]] = drv_data[g];
          end else begin
            e_rd_v[n] = 1'b1; e_rd_a[n] = drv_addr[g];
            e_r1_v[n] = 1'b1; e_r1_t[n] = g; e_r1_d[n] = mem_ref[n][drv_addr[g]];
          end
          $display("cyc %0d %s grant r%0d %s addr=%0h", cyc, p, g, we[g] ? "WR" : "RD", drv_addr[g]);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ram_clear = 1'b1; addr_max = DEPTH - 1;
    for (int n = 0; n < NI; n++) begin
      model_reset(n);
      e_wr_v[n] = 1'b0; e_wr_a[n] = '0; e_wr_d[n] = '0; e_rd_v[n] = 1'b0; e_rd_a[n] = '0;
      e_r1_v[n] = 1'b0; e_r2_v[n] = 1'b0; e_r1_t[n] = 0; e_r2_t[n] = 0;
      e_r1_d[n] = '0; e_r2_d[n] = '0;
      for (int a = 0; a < DEPTH; a++) mem_ref[n][a] = '0;
    end
    for (int i = 0; i < N; i++) begin drv_addr[i] = '0; drv_data[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    ram_clear = 1'b0;

    // Reset state: valid requests present but nothing is accepted.
    rand_payload(); step(4'hF, 4'h5, 1'b1);
    rand_payload(); step(4'hF, 4'h0, 1'b1);

    // Requester 0 writes then reads back address 3.
    drv_addr[0] = 4'd3; drv_data[0] = 32'hDEADBEEF; step(4'b0001, 4'b0001, 1'b0);
    drv_addr[0] = 4'd3; drv_data[0] = 32'h0;        step(4'b0001, 4'b0000, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b0);

    // All four requesters read continuously.
    repeat (32) begin rand_payload(); step(4'hF, 4'h0, 1'b0); end
    repeat (2) step(4'b0000, 4'b0000, 1'b0);

    // Only requesters 1 and 3 active.
    repeat (16) begin rand_payload(); step(4'b1010, 4'h0, 1'b0); end
    repeat (2) step(4'b0000, 4'b0000, 1'b0);

    // Owner 2 drops mid-burst while requester 0 waits.
    rand_payload(); step(4'b0100, 4'h0, 1'b0);
    rand_payload(); step(4'b0101, 4'h0, 1'b0);
    rand_payload(); step(4'b0001, 4'h0, 1'b0);
    repeat (6) begin rand_payload(); step(4'b1001, 4'h0, 1'b0); end
    repeat (2) step(4'b0000, 4'b0000, 1'b0);

    // Single requester streaming past several bursts.
    repeat (10) begin rand_payload(); step(4'b0010, 4'($urandom_range(0, 15)), 1'b0); end
    repeat (2) step(4'b0000, 4'b0000, 1'b0);

    // Reset right after an accepted read.
    rand_payload(); step(4'b0001, 4'b0000, 1'b0);
    rand_payload(); step(4'hF, 4'($urandom_range(0, 15)), 1'b1);
    rand_payload(); step(4'hF, 4'h0, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b0);

    // Random traffic on a small address window to exercise read-after-write.
    addr_max = 3;
    repeat (400) begin
      rand_payload();
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    end
    repeat (4) step(4'b0000, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
